// File: rtl/ddr_port_arbiter_if.sv
// Bundle for the requester side and the physical DDR side of ddr_port_arbiter.
// The arbiter uses the slave modport; the masters and the DDR controller use the master modport.
interface ddr_port_arbiter_if #(
    parameter int unsigned NumReq = 2
);
    localparam int unsigned GrantW = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [NumReq-1:0]    req_req;
    logic [NumReq*64-1:0] req_wdata;
    logic [NumReq*8-1:0]  req_wstrb;
    logic [NumReq*32-1:0] req_addr;
    logic [63:0]          req_rdata;
    logic [NumReq-1:0]    req_ready;
    logic [NumReq-1:0]    req_busy;
    logic [NumReq-1:0]    req_err;
    logic [GrantW-1:0]    grant;

    logic                 ddr_req;
    logic [63:0]          ddr_wdata;
    logic [7:0]           ddr_wstrb;
    logic [31:0]          ddr_addr;
    logic [63:0]          ddr_rdata;
    logic                 ddr_ready;
    logic                 ddr_busy;

    modport slave (
        input  req_req, req_wdata, req_wstrb, req_addr, ddr_rdata, ddr_ready, ddr_busy,
        output req_rdata, req_ready, req_busy, req_err, grant,
        output ddr_req, ddr_wdata, ddr_wstrb, ddr_addr
    );

    modport master (
        output req_req, req_wdata, req_wstrb, req_addr, ddr_rdata, ddr_ready, ddr_busy,
        input  req_rdata, req_ready, req_busy, req_err, grant,
        input  ddr_req, ddr_wdata, ddr_wstrb, ddr_addr
    );
endinterface

// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing one DDR request port among NumReq masters.
// Optional ISSUE timeout abort enabled by defining DDR_ARB_TIMEOUT_EN.
module ddr_port_arbiter #(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                clk,
    input  logic                reset_n,
    ddr_port_arbiter_if.slave   bus
);
    localparam int unsigned GrantW = (NumReq > 1) ? $clog2(NumReq) : 1;

    if (NumReq < 2 || NumReq > 8 || TimeoutCycles < 2 || TimeoutCycles > 65536) begin : g_param_check
        $error("ddr_port_arbiter: parameter out of range");
    end

    typedef enum logic {S_IDLE, S_ISSUE} state_e;

    state_e            state_q, state_d;
    logic [GrantW-1:0] grant_q, grant_d;
    logic [GrantW-1:0] rr_ptr_q, rr_ptr_d;
    logic [GrantW-1:0] pick_c;
    logic              found_c;
    logic              timeout_c;

`ifdef DDR_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    // Counter is held at zero in IDLE, so it starts from zero on every new grant.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE) cnt_d = '0;
        else                   cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign timeout_c = (state_q == S_ISSUE) && !bus.ddr_ready &&
                       (cnt_q == 16'(TimeoutCycles - 1));
`else
    assign timeout_c = 1'b0;
`endif

    // Search from rr_ptr upward, wrapping exactly at NumReq.
    always_comb begin
        logic [GrantW-1:0] idx;
        pick_c  = rr_ptr_q;
        found_c = 1'b0;
        idx     = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            if (int'(rr_ptr_q) + i >= int'(NumReq)) idx = GrantW'(int'(rr_ptr_q) + i - int'(NumReq));
            else                                    idx = GrantW'(int'(rr_ptr_q) + i);
            if (!found_c && bus.req_req[idx]) begin
                found_c = 1'b1;
                pick_c  = idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        bus.ddr_req   = 1'b0;
        bus.ddr_wdata = '0;
        bus.ddr_wstrb = '0;
        bus.ddr_addr  = '0;
        bus.req_rdata = '0;
        bus.req_ready = '0;
        bus.req_err   = '0;
        bus.req_busy  = {NumReq{bus.ddr_busy}};

        case (state_q)
            S_IDLE: begin
                if (!bus.ddr_busy && found_c) begin
                    grant_d = pick_c;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.ddr_req = 1'b1;
                for (int i = 0; i < int'(NumReq); i++) begin
                    if (GrantW'(i) == grant_q) begin
                        bus.ddr_wdata    = bus.req_wdata[64*i +: 64];
                        bus.ddr_wstrb    = bus.req_wstrb[8*i +: 8];
                        bus.ddr_addr     = bus.req_addr[32*i +: 32];
                        bus.req_ready[i] = bus.ddr_ready | timeout_c;
                        bus.req_err[i]   = timeout_c;
                    end else begin
                        bus.req_busy[i]  = 1'b1;
                    end
                end
                if (bus.ddr_ready) bus.req_rdata = bus.ddr_rdata;
                if (bus.ddr_ready || timeout_c) begin
                    rr_ptr_d = (grant_q == GrantW'(NumReq - 1)) ? '0 : grant_q + 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.grant = grant_q;
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed bench for ddr_port_arbiter with two masters; the timeout scenario follows DDR_ARB_TIMEOUT_EN.
module tb_ddr_port_arbiter;
    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    ddr_port_arbiter_if #(.NumReq(2)) bus ();

    ddr_port_arbiter #(.NumReq(2), .TimeoutCycles(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_req   = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        bus.req_addr  = '0;
        bus.ddr_rdata = '0;
        bus.ddr_ready = 1'b0;
        bus.ddr_busy  = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        step();
        step();
        #1;
        n_cmp++;
        if ({bus.ddr_req, bus.grant, bus.req_ready, bus.req_busy, bus.req_err} !== 8'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl got req=%b grant=%b rdy=%b busy=%b err=%b exp all 0",
                     bus.ddr_req, bus.grant, bus.req_ready, bus.req_busy, bus.req_err);
        end
        n_cmp++;
        if ({bus.ddr_addr, bus.ddr_wdata, bus.req_rdata} !== 160'b0) begin
            n_bad++;
            $display("FAIL reset_data got addr=%h wdata=%h rdata=%h exp 0", bus.ddr_addr, bus.ddr_wdata, bus.req_rdata);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single_write();
        int high;
        high = 0;
        bus.req_wdata[63:0] = 64'h41;
        bus.req_wstrb[7:0]  = 8'hff;
        bus.req_addr[31:0]  = 32'h1000_0000;
        bus.req_req         = 2'b01;
        step();
        #1;
        n_cmp++;
        if (bus.ddr_addr !== 32'h1000_0000 || bus.ddr_wstrb !== 8'hff || bus.ddr_wdata !== 64'h41 || bus.grant !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_payload got addr=%h strb=%h wdata=%h grant=%b exp 10000000/ff/41/0",
                     bus.ddr_addr, bus.ddr_wstrb, bus.ddr_wdata, bus.grant);
        end
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) bus.ddr_ready = 1'b1;
            #1;
            if (bus.ddr_req === 1'b1) high++;
            n_cmp++;
            if (bus.req_ready !== ((c == 5) ? 2'b01 : 2'b00)) begin
                n_bad++;
                $display("FAIL wr_ready cyc%0d got=%b exp=%b", c, bus.req_ready, (c == 5) ? 2'b01 : 2'b00);
            end
            step();
        end
        bus.ddr_ready = 1'b0;
        bus.req_req   = 2'b00;
        #1;
        n_cmp++;
        if (bus.ddr_req !== 1'b0 || bus.req_ready !== 2'b00 || bus.grant !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_after got req=%b rdy=%b grant=%b exp 0/00/0", bus.ddr_req, bus.req_ready, bus.grant);
        end
        n_cmp++;
        if (high !== 5) begin
            n_bad++;
            $display("FAIL wr_req_len got=%0d exp=5", high);
        end
    endtask

    task automatic test_two_masters();
        do_reset();
        bus.req_addr = {32'h3000_0040, 32'h2000_0000};
        bus.req_req  = 2'b11;
        step();
        #1;
        n_cmp++;
        if (bus.grant !== 1'b0 || bus.ddr_addr !== 32'h2000_0000 || bus.req_busy !== 2'b10) begin
            n_bad++;
            $display("FAIL rr_first got grant=%b addr=%h busy=%b exp 0/20000000/10", bus.grant, bus.ddr_addr, bus.req_busy);
        end
        bus.ddr_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.req_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL rr_first_rdy got=%b exp=01", bus.req_ready);
        end
        step();
        bus.ddr_ready = 1'b0;
        bus.req_req   = 2'b10;
        #1;
        n_cmp++;
        if (bus.ddr_req !== 1'b0) begin
            n_bad++;
            $display("FAIL rr_idle_gap got=%b exp=0", bus.ddr_req);
        end
        step();
        #1;
        n_cmp++;
        if (bus.grant !== 1'b1 || bus.ddr_addr !== 32'h3000_0040 || bus.req_busy !== 2'b01) begin
            n_bad++;
            $display("FAIL rr_second got grant=%b addr=%h busy=%b exp 1/30000040/01", bus.grant, bus.ddr_addr, bus.req_busy);
        end
        bus.req_req   = 2'b11;
        bus.ddr_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.req_ready !== 2'b10) begin
            n_bad++;
            $display("FAIL rr_second_rdy got=%b exp=10", bus.req_ready);
        end
        step();
        bus.ddr_ready = 1'b0;
        bus.req_req   = 2'b01;
        step();
        #1;
        n_cmp++;
        if (bus.grant !== 1'b0 || bus.ddr_addr !== 32'h2000_0000 || bus.ddr_req !== 1'b1) begin
            n_bad++;
            $display("FAIL rr_third got grant=%b addr=%h req=%b exp 0/20000000/1", bus.grant, bus.ddr_addr, bus.ddr_req);
        end
        bus.ddr_ready = 1'b1;
        step();
        bus.ddr_ready = 1'b0;
        bus.req_req   = 2'b00;
        step();
    endtask

    task automatic test_busy_gate();
        int seen;
        seen = 0;
        bus.ddr_busy = 1'b1;
        bus.req_req  = 2'b10;
        for (int c = 0; c < 20; c++) begin
            step();
            #1;
            if (bus.ddr_req !== 1'b0 || bus.req_busy !== 2'b11) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL busy_hold got %0d bad cycles exp 0", seen);
        end
        bus.ddr_busy = 1'b0;
        step();
        #1;
        n_cmp++;
        if (bus.ddr_req !== 1'b1 || bus.grant !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_release got req=%b grant=%b exp 1/1", bus.ddr_req, bus.grant);
        end
        bus.ddr_busy  = 1'b1;
        bus.ddr_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.ddr_req !== 1'b1 || bus.req_ready !== 2'b10) begin
            n_bad++;
            $display("FAIL busy_in_issue got req=%b rdy=%b exp 1/10", bus.ddr_req, bus.req_ready);
        end
        step();
        bus.ddr_ready = 1'b0;
        bus.ddr_busy  = 1'b0;
        bus.req_req   = 2'b00;
        step();
    endtask

    task automatic test_read();
        bus.req_wstrb[15:8] = 8'h00;
        bus.req_addr[63:32] = 32'h3000_0080;
        bus.req_req         = 2'b10;
        step();
        bus.ddr_rdata = 64'hDEAD_BEEF_0000_0055;
        #1;
        n_cmp++;
        if (bus.req_rdata !== 64'h0 || bus.req_busy !== 2'b01 || bus.ddr_wstrb !== 8'h00 || bus.ddr_addr !== 32'h3000_0080) begin
            n_bad++;
            $display("FAIL rd_issue got rdata=%h busy=%b strb=%h addr=%h exp 0/01/00/30000080",
                     bus.req_rdata, bus.req_busy, bus.ddr_wstrb, bus.ddr_addr);
        end
        bus.ddr_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.req_rdata !== 64'hDEAD_BEEF_0000_0055 || bus.req_ready !== 2'b10) begin
            n_bad++;
            $display("FAIL rd_data got rdata=%h rdy=%b exp deadbeef00000055/10", bus.req_rdata, bus.req_ready);
        end
        step();
        bus.ddr_ready = 1'b0;
        bus.ddr_rdata = '0;
        bus.req_req   = 2'b00;
        step();
    endtask

    task automatic test_reset_mid_issue();
        bus.req_req = 2'b10;
        step();
        step();
        reset_n       = 1'b0;
        bus.ddr_ready = 1'b1;
        step();
        #1;
        n_cmp++;
        if (bus.ddr_req !== 1'b0 || bus.grant !== 1'b0 || bus.req_ready !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_issue got req=%b grant=%b rdy=%b exp 0/0/00", bus.ddr_req, bus.grant, bus.req_ready);
        end
        reset_n       = 1'b1;
        bus.ddr_ready = 1'b0;
        bus.req_req   = 2'b11;
        step();
        #1;
        n_cmp++;
        if (bus.ddr_req !== 1'b1 || bus.grant !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_restart got req=%b grant=%b exp 1/0", bus.ddr_req, bus.grant);
        end
        bus.ddr_ready = 1'b1;
        step();
        bus.ddr_ready = 1'b0;
        bus.req_req   = 2'b00;
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        bus.ddr_rdata = 64'h1234_5678_9abc_def0;
        bus.req_req   = 2'b11;
        step();
`ifdef DDR_ARB_TIMEOUT_EN
        for (int c = 1; c <= 8; c++) begin
            #1;
            n_cmp++;
            if ({bus.req_err, bus.req_ready} !== ((c == 8) ? 4'b0101 : 4'b0000) || bus.req_rdata !== 64'h0) begin
                n_bad++;
                $display("FAIL to_abort cyc%0d got err=%b rdy=%b rdata=%h", c, bus.req_err, bus.req_ready, bus.req_rdata);
            end
            step();
        end
        bus.req_req = 2'b10;
        step();
        #1;
        n_cmp++;
        if (bus.grant !== 1'b1 || bus.ddr_req !== 1'b1) begin
            n_bad++;
            $display("FAIL to_next got grant=%b req=%b exp 1/1", bus.grant, bus.ddr_req);
        end
        bus.ddr_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.req_err !== 2'b00 || bus.req_ready !== 2'b10) begin
            n_bad++;
            $display("FAIL to_normal got err=%b rdy=%b exp 00/10", bus.req_err, bus.req_ready);
        end
`else
        for (int c = 1; c <= 20; c++) begin
            #1;
            n_cmp++;
            if ({bus.ddr_req, bus.req_err, bus.req_ready} !== 5'b10000 || bus.grant !== 1'b0) begin
                n_bad++;
                $display("FAIL to_hold cyc%0d got req=%b err=%b rdy=%b grant=%b exp 1/00/00/0",
                         c, bus.ddr_req, bus.req_err, bus.req_ready, bus.grant);
            end
            step();
        end
        bus.ddr_ready = 1'b1;
`endif
        step();
        bus.ddr_ready = 1'b0;
        bus.req_req   = 2'b00;
        step();
    endtask

    initial begin
        clk   = 1'b0;
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single_write();
        test_two_masters();
        test_busy_gate();
        test_read();
        test_reset_mid_issue();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
